vrf_read_port_arbiter: RTL
==========================

# vrf_read_port_arbiter

Allocates vector-register read ports to functional-unit requesters in the vector unit. It sits between the issue stage's operand requesters and the vector register array, and drives the array's per-register `r_signal` strobes. Port reservations persist until the requester explicitly releases them. Requesters are served round-robin and share the ports of every register without collisions.

## Interface
Parameters:
- `NUM_REGS`, 32, number of vector registers.
- `NUM_READ_PORTS`, 4, read ports per register.
- `NUM_REQ`, 4, number of requesters.
- Derived: `RW` = bitwidth(`NUM_REGS`) (5); `PW` = bitwidth(`NUM_READ_PORTS`) (2). bitwidth(v) = 1 if v≤1, else ceil(log2 v).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req_valid`  in  `NUM_REQ`  requester i wants a read port.
- `req_reg`  in  `NUM_REQ*RW`  register requested by i, in slice [i*RW +: RW].
- `req_ready`  out  `NUM_REQ`  grant to i, combinational, same cycle.
- `gnt_port`  out  `NUM_REQ*PW`  granted port for i, valid only while `req_ready[i]` is high.
- `rel_valid`  in  `NUM_REQ`  requester i releases a port.
- `rel_reg`  in  `NUM_REQ*RW`  register being released.
- `rel_port`  in  `NUM_REQ*PW`  port being released.
- `busy_read`  in  `NUM_REGS*NUM_READ_PORTS`  array busy flags; bit index = reg*`NUM_READ_PORTS`+port.
- `r_signal`  out  `NUM_REGS*NUM_READ_PORTS`  start-read strobe, same bit layout as `busy_read`.
- `rel_err`  out  1  sticky flag: a release targeted a port that was not reserved.

## Operation
- State:
  - `resv[NUM_REGS*NUM_READ_PORTS]`: reservation bits.
  - `rr_ptr` [bitwidth(`NUM_REQ`)]: round-robin priority pointer.
  - `rel_err`: sticky error flag.
- Port free condition: (reg,p) is free iff `!resv[reg*NRP+p] && !busy_read[reg*NRP+p]`.
- Grant evaluation each cycle (combinational):
  - Visit requesters in order `rr_ptr`, `rr_ptr`+1, …, wrapping modulo `NUM_REQ`.
  - Each valid requester takes the lowest-index free port of its `req_reg` that was not already taken earlier in the same pass.
  - If no port is free, `req_ready[i]`=0.
- Outcome: several requesters may be granted in one cycle, on the same or different registers, up to the number of free ports per register.
- On grant: `r_signal` bit for (reg,port) is high for that cycle only, and `resv` is set at the next edge.
- `rr_ptr` update: at the edge, set to (highest-priority granted requester + 1) mod `NUM_REQ`. Unchanged if nothing was granted.
- Release: `rel_valid[i]` clears `resv` for (`rel_reg`,`rel_port`) at the edge.
  - The released port is not grantable until the following cycle.
  - If that `resv` bit is already 0, the release is a no-op and `rel_err` is set.
- Same-cycle release and grant on the same bit: the grant cannot happen, because the port is still reserved in that cycle.
- Duplicate releases of the same bit in one cycle: clear once; no error.
- `rel_err` clears only on `rst`.

## Timing
- Grant latency: 0 cycles. `req_ready`, `gnt_port` and `r_signal` are combinational from `req_*`, `resv`, `busy_read` and `rr_ptr`.
- Handshake: a requester holds `req_valid` and `req_reg` until it sees `req_ready`=1. A transfer completes on any edge where both are high.
- Release → regrant: at the earliest, the cycle after the `rel_valid` edge.
- Reset: synchronous, active-high. While `rst` is high:
  - `req_ready`=0, `r_signal`=0, `gnt_port`=0.
  - After the edge: `resv`=0, `rr_ptr`=0, `rel_err`=0.
  - Requests and releases in reset cycles are ignored.
  - Reset in the middle of operation drops all reservations.
- No multi-cycle paths; all outputs settle within the cycle.

## Test plan
- Reset, then requester 0 asks for reg 3 → `req_ready[0]`=1, `gnt_port`=0, `r_signal[12]` pulses for 1 cycle, `resv[12]`=1 after the edge.
- Requesters 0–3 all request reg 5 in the same cycle → all granted; ports 0,1,2,3 in rr order from `rr_ptr`; `r_signal[20..23]`=1. A further request to reg 5 stalls until a release.
- Set `busy_read[8]`=1 (reg 2, port 0) and request reg 2 → granted port 1; `r_signal[9]`=1.
- Fairness: with all ports of reg 7 reserved except one, requesters 0 and 1 request reg 7 every cycle while releases recycle the port. Grants must alternate between 0 and 1, with no requester starved more than `NUM_REQ`-1 grants.
- Release (reg 5, port 2) in the same cycle as a request to reg 5 → no grant that cycle; the next cycle grants port 2.
- Release an unreserved (reg 0, port 3) → `rel_err`=1 and stays high until `rst`. Assert `rst` with reservations held → all `resv`=0 and `rel_err`=0 after the edge.

Source files
------------

// File: rtl/vrf_read_port_arbiter_if.sv
// rtl/vrf_read_port_arbiter_if.sv - request/grant/release bundle between operand requesters and the read-port arbiter
//
// Signals (widths from NUM_REGS / NUM_READ_PORTS / NUM_REQ):
//   req_valid, req_reg          requester -> arbiter, one slot of RW bits per requester
//   req_ready, gnt_port         arbiter -> requester, same-cycle grant and granted port
//   rel_valid, rel_reg, rel_port requester -> arbiter, explicit port release
//   busy_read                   register array -> arbiter, bit reg*NUM_READ_PORTS+port
//   r_signal                    arbiter -> register array, start-read strobes
//   rel_err                     arbiter -> status, sticky bad-release flag
interface vrf_read_port_arbiter_if #(
    parameter int NUM_REGS       = 32,
    parameter int NUM_READ_PORTS = 4,
    parameter int NUM_REQ        = 4
);
    localparam int RW = (NUM_REGS <= 1) ? 1 : $clog2(NUM_REGS);
    localparam int PW = (NUM_READ_PORTS <= 1) ? 1 : $clog2(NUM_READ_PORTS);
    localparam int NB = NUM_REGS * NUM_READ_PORTS;

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*RW-1:0] req_reg;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*PW-1:0] gnt_port;
    logic [NUM_REQ-1:0]    rel_valid;
    logic [NUM_REQ*RW-1:0] rel_reg;
    logic [NUM_REQ*PW-1:0] rel_port;
    logic [NB-1:0]         busy_read;
    logic [NB-1:0]         r_signal;
    logic                  rel_err;

    modport master (
        output req_valid, req_reg, rel_valid, rel_reg, rel_port, busy_read,
        input  req_ready, gnt_port, r_signal, rel_err
    );

    modport slave (
        input  req_valid, req_reg, rel_valid, rel_reg, rel_port, busy_read,
        output req_ready, gnt_port, r_signal, rel_err
    );
endinterface

// File: rtl/vrf_read_port_arbiter.sv
// rtl/vrf_read_port_arbiter.sv - round-robin allocator of vector-register read ports to requesters
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset; drops all reservations and the sticky error
//   bus  - slave side of vrf_read_port_arbiter_if (requests, grants, releases,
//          busy flags in, start-read strobes out, sticky rel_err out)
//
// Grants are combinational: each cycle the requesters are visited starting at
// rr_ptr and each valid one takes the lowest free port of its register that no
// earlier requester in the same pass has taken. A granted port stays reserved
// until its owner releases it.
module vrf_read_port_arbiter #(
    parameter int NUM_REGS       = 32,
    parameter int NUM_READ_PORTS = 4,
    parameter int NUM_REQ        = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    vrf_read_port_arbiter_if.slave    bus
);
    localparam int RW = (NUM_REGS <= 1) ? 1 : $clog2(NUM_REGS);
    localparam int PW = (NUM_READ_PORTS <= 1) ? 1 : $clog2(NUM_READ_PORTS);
    localparam int QW = (NUM_REQ <= 1) ? 1 : $clog2(NUM_REQ);

    // [reg][port] view matches the flat layout bit = reg*NUM_READ_PORTS + port
    typedef logic [NUM_REGS-1:0][NUM_READ_PORTS-1:0] grid_t;

    grid_t resv;
    grid_t busy;
    grid_t taken;
    grid_t clr;

    logic [NUM_REQ-1:0][RW-1:0] req_reg_v;
    logic [NUM_REQ-1:0][RW-1:0] rel_reg_v;
    logic [NUM_REQ-1:0][PW-1:0] rel_port_v;
    logic [NUM_REQ-1:0][PW-1:0] gnt_c;
    logic [NUM_REQ-1:0]         ready_c;

    logic [QW-1:0] rr_ptr;
    logic [QW-1:0] rr_next;
    logic [QW-1:0] idx;
    logic          any_gnt;
    logic          found;
    logic          err_c;
    logic          rel_err_q;
    int            slot;
    int            nxt;

    assign busy       = bus.busy_read;
    assign req_reg_v  = bus.req_reg;
    assign rel_reg_v  = bus.rel_reg;
    assign rel_port_v = bus.rel_port;

    // Grant pass. taken doubles as the r_signal strobe vector.
    always_comb begin
        taken   = '0;
        ready_c = '0;
        gnt_c   = '0;
        any_gnt = 1'b0;
        rr_next = rr_ptr;
        idx     = '0;
        found   = 1'b0;
        slot    = 0;
        nxt     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            slot = int'(rr_ptr) + k;
            if (slot >= NUM_REQ) begin
                slot = slot - NUM_REQ;
            end
            idx   = QW'(slot);
            found = 1'b0;
            if (!rst && bus.req_valid[idx] && (int'(req_reg_v[idx]) < NUM_REGS)) begin
                for (int p = 0; p < NUM_READ_PORTS; p++) begin
                    if (!found && !resv[req_reg_v[idx]][p] && !busy[req_reg_v[idx]][p]
                        && !taken[req_reg_v[idx]][p]) begin
                        found                    = 1'b1;
                        taken[req_reg_v[idx]][p] = 1'b1;
                        ready_c[idx]             = 1'b1;
                        gnt_c[idx]               = PW'(p);
                    end
                end
                // The first winner in visiting order is the highest-priority grant
                if (found && !any_gnt) begin
                    any_gnt = 1'b1;
                    nxt     = int'(idx) + 1;
                    if (nxt >= NUM_REQ) begin
                        nxt = 0;
                    end
                    rr_next = QW'(nxt);
                end
            end
        end
    end

    // Releases act on the pre-edge reservation state, so duplicates of a held
    // bit both see it set and clear it once without raising an error.
    always_comb begin
        clr   = '0;
        err_c = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.rel_valid[i]) begin
                if ((int'(rel_reg_v[i]) < NUM_REGS) && (int'(rel_port_v[i]) < NUM_READ_PORTS)
                    && resv[rel_reg_v[i]][rel_port_v[i]]) begin
                    clr[rel_reg_v[i]][rel_port_v[i]] = 1'b1;
                end else begin
                    err_c = 1'b1;
                end
            end
        end
    end

    // Grants only land on unreserved bits and releases only clear reserved
    // ones, so the two masks never overlap.
    always_ff @(posedge clk) begin
        if (rst) begin
            resv      <= '0;
            rr_ptr    <= '0;
            rel_err_q <= 1'b0;
        end else begin
            resv   <= (resv & ~clr) | taken;
            rr_ptr <= rr_next;
            if (err_c) begin
                rel_err_q <= 1'b1;
            end
        end
    end

    assign bus.req_ready = ready_c;
    assign bus.gnt_port  = gnt_c;
    assign bus.r_signal  = taken;
    assign bus.rel_err   = rel_err_q;
endmodule
